// File: rtl/rom_msg_streamer.sv
// Walks a combinational character ROM from address 0 and streams each byte over valid/ready,
// stopping at a NUL byte or after MSG_LEN bytes. Optional MSG_REPEAT_EN adds an rpt input for back-to-back replay.
module rom_msg_streamer #(
  parameter int ADDR_W  = 4,
  parameter int MSG_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef MSG_REPEAT_EN
  input  logic              rpt,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   char_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic                done_q;
  logic [ADDR_W:0]     char_count_q;
  logic                repeat_req;

`ifdef MSG_REPEAT_EN
  assign repeat_req = rpt;
`else
  assign repeat_req = 1'b0;
`endif

  // Stream handshake: a byte transfers on a rising edge where tx_valid && tx_ready; once tx_valid
  // is raised, tx_data and tx_valid stay stable until that transfer, and tx_ready alone does nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      char_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rom_addr_q   <= '0;
            char_count_q <= '0;
            state_q      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rom_data == 8'h00) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tx_data_q  <= rom_data;
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_valid_q   <= 1'b0;
            char_count_q <= char_count_q + (ADDR_W+1)'(1);
            if (rom_addr_q == LAST_ADDR) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rom_addr_q <= rom_addr_q + ADDR_W'(1);
              state_q    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          // done is high only for the single cycle spent here.
          done_q     <= 1'b0;
          rom_addr_q <= '0;
          if (repeat_req) begin
            char_count_q <= '0;
            state_q      <= S_FETCH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr   = rom_addr_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign done       = done_q;
  assign char_count = char_count_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rom_msg_streamer.sv
// Scoreboard bench for rom_msg_streamer: a "ENGINEERING" ROM on a MSG_LEN=16 instance and a
// NUL-free ROM on a MSG_LEN=4 instance; define MSG_REPEAT_EN to also exercise rpt.
module tb_rom_msg_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0, tx_ready = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data, tx_data;
  logic       tx_valid, busy, done;
  logic [4:0] char_count;
  logic [1:0] dbg_state;

  logic       start4 = 1'b0, tx_ready4 = 1'b0;
  logic [3:0] rom_addr4;
  logic [7:0] rom_data4, tx_data4;
  logic       tx_valid4, busy4, done4;
  logic [4:0] char_count4;
  logic [1:0] dbg_state4;
`ifdef MSG_REPEAT_EN
  logic rpt = 1'b0, rpt4 = 1'b0;
`endif

  logic [7:0] rom [16];
  logic [7:0] rom4[16];
  logic [7:0] msg [11] = '{8'h45, 8'h4E, 8'h47, 8'h49, 8'h4E, 8'h45, 8'h45, 8'h52, 8'h49, 8'h4E, 8'h47};

  assign rom_data  = rom[rom_addr];
  assign rom_data4 = rom4[rom_addr4];

  rom_msg_streamer #(.ADDR_W(4), .MSG_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef MSG_REPEAT_EN
    .rpt(rpt),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .char_count(char_count), .dbg_state(dbg_state)
  );

  rom_msg_streamer #(.ADDR_W(4), .MSG_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
`ifdef MSG_REPEAT_EN
    .rpt(rpt4),
`endif
    .rom_addr(rom_addr4), .rom_data(rom_data4), .tx_data(tx_data4), .tx_valid(tx_valid4),
    .tx_ready(tx_ready4), .busy(busy4), .done(done4), .char_count(char_count4), .dbg_state(dbg_state4)
  );

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];
  int acc_cnt = 0, done_cnt = 0, done4_cnt = 0, max_addr4 = 0;
  bit prev_acc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the 16-byte instance: pops the expected queue on every accepted byte.
  always @(negedge clk) begin
    if (prev_acc) check("gap_after_accept", 32'(tx_valid), 32'd0);
    prev_acc = 1'b0;
    if (rst_n && done) done_cnt++;
    if (rst_n && tx_valid && tx_ready) begin
      acc_cnt++;
      prev_acc = 1'b1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) done4_cnt++;
    if (rst_n && busy4 && int'(rom_addr4) > max_addr4) max_addr4 = int'(rom_addr4);
    if (rst_n && tx_valid4 && tx_ready4) begin
      if (exp4_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte4: got %0h expected none", tx_data4);
      end else begin
        check("tx_byte4", 32'(tx_data4), 32'(exp4_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_msg();
    for (int i = 0; i < 11; i++) exp_q.push_back(msg[i]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_acc(input string name, input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check({name, "_acc_reached"}, 32'(acc_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_reached"}, 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    for (int i = 0; i < 16; i++) rom[i] = (i < 11) ? msg[i] : 8'h00;
    for (int i = 0; i < 16; i++) rom4[i] = (i < 11) ? msg[i] : 8'h58;

    // Reset state
    #1;
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_char_count", 32'(char_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: full message with sink always ready
    tx_ready = 1'b1;
    base = done_cnt;
    push_msg();
    pulse_start();
    check("t1_busy_after_start", 32'(busy), 32'd1);
    tick();
    check("t1_first_valid", 32'(tx_valid), 32'd1);
    wait_idle("t1", 200);
    check("t1_done_once", 32'(done_cnt - base), 32'd1);
    check("t1_char_count", 32'(char_count), 32'd11);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check("t1_count_held", 32'(char_count), 32'd11);

    // 2: sink stalls 5 cycles on the 3rd byte
    base = acc_cnt;
    push_msg();
    pulse_start();
    wait_acc("t2", base + 2, 100);
    tx_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(tx_valid), 32'd1);
      check("t2_hold_data", 32'(tx_data), 32'h47);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle("t2", 200);
    check("t2_char_count", 32'(char_count), 32'd11);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: NUL-free ROM on the MSG_LEN=4 instance
    tx_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) exp4_q.push_back(msg[i]);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int n = 0; n < 100 && busy4; n++) tick();
    check("t3_idle", 32'(busy4), 32'd0);
    check("t3_done_once", 32'(done4_cnt), 32'd1);
    check("t3_char_count", 32'(char_count4), 32'd4);
    check("t3_max_addr", 32'(max_addr4), 32'd3);
    check("t3_q_empty", 32'(exp4_q.size()), 32'd0);
    check("t3_addr_back", 32'(rom_addr4), 32'd0);

    // 4: async reset while the 6th byte waits in SEND
    base = acc_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(msg[i]);
    pulse_start();
    wait_acc("t4", base + 5, 100);
    tx_ready = 1'b0;
    tick();
    check("t4_sixth_valid", 32'(tx_valid), 32'd1);
    check("t4_sixth_data", 32'(tx_data), 32'h45);
    rst_n = 1'b0;
    #1;
    check("t4_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("t4_rst_tx_data", 32'(tx_data), 32'd0);
    check("t4_rst_rom_addr", 32'(rom_addr), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    check("t4_rst_char_count", 32'(char_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tx_ready = 1'b1;
    push_msg();
    pulse_start();
    wait_idle("t4", 200);
    check("t4_char_count", 32'(char_count), 32'd11);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: start held high yields one message per acceptance
    base = done_cnt;
    push_msg();
    push_msg();
    start = 1'b1;
    wait_done("t5", base + 2, 400);
    start = 1'b0;
    check("t5_back_to_idle", 32'(busy), 32'd0);
    tick();
    check("t5_stays_idle", 32'(busy), 32'd0);
    check("t5_done_twice", 32'(done_cnt - base), 32'd2);
    check("t5_char_count", 32'(char_count), 32'd11);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // NUL at address 0: done with nothing emitted
    rom[0] = 8'h00;
    base = done_cnt;
    pulse_start();
    wait_idle("t7", 50);
    check("t7_done_once", 32'(done_cnt - base), 32'd1);
    check("t7_char_count", 32'(char_count), 32'd0);
    rom[0] = msg[0];

`ifdef MSG_REPEAT_EN
    // 6: rpt replays the message with no IDLE cycle
    rpt = 1'b1;
    base = done_cnt;
    push_msg();
    push_msg();
    pulse_start();
    wait_done("t6", base + 1, 200);
    check("t6_no_idle", 32'(busy), 32'd1);
    check("t6_state_fetch", 32'(dbg_state), 32'd1);
    check("t6_count_cleared", 32'(char_count), 32'd0);
    rpt = 1'b0;
    wait_idle("t6", 200);
    check("t6_done_twice", 32'(done_cnt - base), 32'd2);
    check("t6_char_count", 32'(char_count), 32'd11);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
